// File: rtl/velocity_motion_update_dispatcher_pkg.sv
// rtl/velocity_motion_update_dispatcher_pkg.sv - shared state encodings, bundle widths and cell coordinate type
package velocity_motion_update_dispatcher_pkg;
    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 8;
    localparam int CELL_ID_W    = 4;
    localparam int BCAST_DATA_W = 3 * DATA_W;
    localparam int BCAST_CELL_W = 3 * CELL_ID_W;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_CNT    = 3'd1;
    localparam logic [2:0] ST_WAIT_CNT  = 3'd2;
    localparam logic [2:0] ST_RD_PART   = 3'd3;
    localparam logic [2:0] ST_DRAIN     = 3'd4;
    localparam logic [2:0] ST_NEXT_CELL = 3'd5;
    localparam logic [2:0] ST_FINISH    = 3'd6;
    localparam logic [2:0] ST_DONE      = 3'd7;

    typedef struct packed {
        logic [CELL_ID_W-1:0] x;
        logic [CELL_ID_W-1:0] y;
        logic [CELL_ID_W-1:0] z;
    } cell_coord_t;
endpackage

// File: rtl/velocity_motion_update_dispatcher_if.sv
// rtl/velocity_motion_update_dispatcher_if.sv - cell read port and broadcast bus bundle
interface velocity_motion_update_dispatcher_if
    import velocity_motion_update_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W,
    parameter int ADDR_WIDTH    = ADDR_W,
    parameter int CELL_ID_WIDTH = CELL_ID_W
);
    logic [3*CELL_ID_WIDTH-1:0] out_read_cell;
    logic [ADDR_WIDTH-1:0]      out_read_address;
    logic                       out_rden;
    logic [3*DATA_WIDTH-1:0]    in_particle_info;
    logic [3*CELL_ID_WIDTH-1:0] in_particle_dst_cell;
    logic                       out_motion_update_enable;
    logic [3*DATA_WIDTH-1:0]    out_data;
    logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell;
    logic                       out_data_valid;

    modport master (
        output out_read_cell, out_read_address, out_rden,
        output out_motion_update_enable, out_data, out_data_dst_cell, out_data_valid,
        input  in_particle_info, in_particle_dst_cell
    );

    modport slave (
        input  out_read_cell, out_read_address, out_rden,
        input  out_motion_update_enable, out_data, out_data_dst_cell, out_data_valid,
        output in_particle_info, in_particle_dst_cell
    );
endinterface

// File: rtl/velocity_motion_update_dispatcher_cell_coord_iterator.sv
// rtl/velocity_motion_update_dispatcher_cell_coord_iterator.sv - 1-based 3-D cell walker, z fastest
module cell_coord_iterator
    import velocity_motion_update_dispatcher_pkg::*;
#(
    parameter int X_DIM = 4,
    parameter int Y_DIM = 4,
    parameter int Z_DIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output cell_coord_t coord,
    output logic        last
);
    localparam logic [CELL_ID_W-1:0] ONE = CELL_ID_W'(1);
    localparam logic [CELL_ID_W-1:0] XM  = CELL_ID_W'(X_DIM);
    localparam logic [CELL_ID_W-1:0] YM  = CELL_ID_W'(Y_DIM);
    localparam logic [CELL_ID_W-1:0] ZM  = CELL_ID_W'(Z_DIM);

    assign last = (coord.x == XM) && (coord.y == YM) && (coord.z == ZM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coord <= '0;
        end else if (load) begin
            coord.x <= ONE;
            coord.y <= ONE;
            coord.z <= ONE;
        end else if (step) begin
            if (coord.z == ZM) begin
                coord.z <= ONE;
                if (coord.y == YM) begin
                    coord.y <= ONE;
                    coord.x <= coord.x + ONE;
                end else begin
                    coord.y <= coord.y + ONE;
                end
            end else begin
                coord.z <= coord.z + ONE;
            end
        end
    end
endmodule

// File: rtl/velocity_motion_update_dispatcher.sv
// rtl/velocity_motion_update_dispatcher.sv - walks all cells and re-broadcasts their particles
// DISPATCH_STATS_EN adds out_total_particles / out_empty_cells pass statistics.
module velocity_motion_update_dispatcher
    import velocity_motion_update_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W,
    parameter int ADDR_WIDTH    = ADDR_W,
    parameter int CELL_ID_WIDTH = CELL_ID_W,
    parameter int X_DIM         = 4,
    parameter int Y_DIM         = 4,
    parameter int Z_DIM         = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_start,
    velocity_motion_update_dispatcher_if.master bus,
    output logic out_busy,
    output logic out_done
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0] out_total_particles,
    output logic [7:0]  out_empty_cells
`endif
);
    logic [2:0]                 state;
    logic                       tmr;
    logic [ADDR_WIDTH-1:0]      count;
    logic [ADDR_WIDTH-1:0]      part_addr;
    logic [1:0]                 vld_sr;
    logic [3*DATA_WIDTH-1:0]    info;
    logic [3*CELL_ID_WIDTH-1:0] coord_bits;
    logic                       count_zero;
    cell_coord_t                coord;
    logic                       coord_last;
    logic                       coord_load;
    logic                       coord_step;

    assign info       = bus.in_particle_info;
    assign coord_bits = coord;
    assign count_zero = (info[ADDR_WIDTH-1:0] == '0);
    assign coord_load = (state == ST_IDLE) && in_start;
    assign coord_step = (state == ST_NEXT_CELL) && !coord_last;

    cell_coord_iterator #(.X_DIM(X_DIM), .Y_DIM(Y_DIM), .Z_DIM(Z_DIM)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .load  (coord_load),
        .step  (coord_step),
        .coord (coord),
        .last  (coord_last)
    );

    // tmr times the fixed two-cycle WAIT_CNT, DRAIN and FINISH holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tmr       <= 1'b0;
            count     <= '0;
            part_addr <= '0;
        end else begin
            case (state)
                ST_IDLE:      if (in_start) state <= ST_RD_CNT;
                ST_RD_CNT: begin
                    tmr   <= 1'b0;
                    state <= ST_WAIT_CNT;
                end
                ST_WAIT_CNT: begin
                    if (tmr) begin
                        tmr       <= 1'b0;
                        count     <= info[ADDR_WIDTH-1:0];
                        part_addr <= ADDR_WIDTH'(1);
                        state     <= count_zero ? ST_DRAIN : ST_RD_PART;
                    end else begin
                        tmr <= 1'b1;
                    end
                end
                ST_RD_PART: begin
                    if (part_addr == count) begin
                        tmr   <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        part_addr <= part_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tmr) begin
                        tmr   <= 1'b0;
                        state <= ST_NEXT_CELL;
                    end else begin
                        tmr <= 1'b1;
                    end
                end
                ST_NEXT_CELL: begin
                    tmr   <= 1'b0;
                    state <= coord_last ? ST_FINISH : ST_RD_CNT;
                end
                ST_FINISH: begin
                    if (tmr) begin
                        tmr   <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        tmr <= 1'b1;
                    end
                end
                ST_DONE:      state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    // The shift register tracks particle reads so count readouts never reach the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr                <= '0;
            bus.out_data_valid    <= 1'b0;
            bus.out_data          <= '0;
            bus.out_data_dst_cell <= '0;
        end else begin
            vld_sr                <= {vld_sr[0], state == ST_RD_PART};
            bus.out_data_valid    <= vld_sr[1];
            bus.out_data          <= vld_sr[1] ? info : '0;
            bus.out_data_dst_cell <= vld_sr[1] ? bus.in_particle_dst_cell : '0;
        end
    end

    assign bus.out_rden         = (state == ST_RD_CNT) || (state == ST_RD_PART);
    assign bus.out_read_address = (state == ST_RD_PART) ? part_addr : '0;
    assign bus.out_read_cell    = (state == ST_IDLE) ? '0 : coord_bits;
    assign bus.out_motion_update_enable =
        state inside {ST_RD_CNT, ST_WAIT_CNT, ST_RD_PART, ST_DRAIN, ST_NEXT_CELL};
    assign out_busy = (state != ST_IDLE);
    assign out_done = (state == ST_DONE);

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_total_particles <= '0;
            out_empty_cells     <= '0;
        end else if (coord_load) begin
            out_total_particles <= '0;
            out_empty_cells     <= '0;
        end else begin
            if (bus.out_data_valid)
                out_total_particles <= out_total_particles + 16'd1;
            if ((state == ST_WAIT_CNT) && tmr && count_zero)
                out_empty_cells <= out_empty_cells + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_velocity_motion_update_dispatcher.sv
// tb/tb_velocity_motion_update_dispatcher.sv - scoreboard bench for the motion-update dispatcher
module tb_velocity_motion_update_dispatcher;
    localparam int XD = 2;
    localparam int YD = 2;
    localparam int ZD = 2;
    localparam int NC = XD * YD * ZD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_start = 1'b0;
    logic out_busy, out_done;
`ifdef DISPATCH_STATS_EN
    logic [15:0] out_total_particles;
    logic [7:0]  out_empty_cells;
`endif

    velocity_motion_update_dispatcher_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CELL_ID_WIDTH(4)) bus ();

    velocity_motion_update_dispatcher #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .CELL_ID_WIDTH(4),
        .X_DIM(XD), .Y_DIM(YD), .Z_DIM(ZD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_start (in_start),
        .bus      (bus),
        .out_busy (out_busy),
        .out_done (out_done)
`ifdef DISPATCH_STATS_EN
        ,
        .out_total_particles (out_total_particles),
        .out_empty_cells     (out_empty_cells)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cnt [NC];
    logic fixed_dst = 1'b0;
    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    function automatic int cell_count(input logic [11:0] c);
        int x, y, z;
        x = int'(c[11:8]); y = int'(c[7:4]); z = int'(c[3:0]);
        if (x < 1 || x > XD || y < 1 || y > YD || z < 1 || z > ZD) return 0;
        return cnt[((x - 1) * YD + (y - 1)) * ZD + (z - 1)];
    endfunction

    function automatic logic [95:0] part_data(input logic [11:0] c, input logic [7:0] a);
        return {20'hB00B0, c, 24'h0, a, 20'hC0DE0, c};
    endfunction

    function automatic logic [11:0] dst_of(input logic [11:0] c, input logic [7:0] a);
        if (fixed_dst) return 12'h142;
        return c ^ {a[3:0], 8'h00};
    endfunction

    // Cell memory model: readout appears two cycles after the read request.
    logic p1_rd, p2_rd;
    logic [11:0] p1_cell, p2_cell;
    logic [7:0] p1_a, p2_a;
    always @(posedge clk) begin
        p1_rd <= bus.out_rden; p1_cell <= bus.out_read_cell; p1_a <= bus.out_read_address;
        p2_rd <= p1_rd;        p2_cell <= p1_cell;           p2_a <= p1_a;
    end
    assign bus.in_particle_info = !p2_rd ? 96'h0 :
        (p2_a == 8'h0) ? {32'hDEADBEEF, 32'h12345678, 24'hA5A5A5, 8'(cell_count(p2_cell))}
                       : part_data(p2_cell, p2_a);
    assign bus.in_particle_dst_cell = (p2_rd && p2_a != 8'h0) ? dst_of(p2_cell, p2_a) : 12'h0;

    logic [107:0] exp_q [$];
    int n_valid, n_en, n_done, n_142, done_cyc;

    always @(negedge clk) begin
        logic [107:0] e;
        if (!rst) begin
            if (bus.out_data_valid) begin
                n_valid++;
                if (bus.out_data_dst_cell == 12'h142) n_142++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("bcast_data", bus.out_data, e[107:12]);
                    chk("bcast_dst", bus.out_data_dst_cell, e[11:0]);
                end
            end else begin
                chk("idle_bus_zero", {bus.out_data, bus.out_data_dst_cell}, 0);
            end
            if (bus.out_motion_update_enable) n_en++;
            if (out_done) begin n_done++; done_cyc = cyc; end
        end
    end

    task automatic pulse_start(output int at_cyc);
        @(negedge clk);
        in_start = 1'b1;
        at_cyc = cyc;
        @(negedge clk);
        in_start = 1'b0;
    endtask

    task automatic run_pass(input string tag, input int restart_after);
        int s_cyc, s_exp, n_exp, e_exp, dummy;
        s_exp = 0; n_exp = 0; e_exp = 0;
        n_valid = 0; n_en = 0; n_done = 0; n_142 = 0; done_cyc = -1;
        exp_q.delete();
        for (int x = 1; x <= XD; x++)
            for (int y = 1; y <= YD; y++)
                for (int z = 1; z <= ZD; z++) begin
                    logic [11:0] c;
                    int k;
                    c = {4'(x), 4'(y), 4'(z)};
                    k = cell_count(c);
                    if (k == 0) e_exp++;
                    for (int a = 1; a <= k; a++)
                        exp_q.push_back({part_data(c, 8'(a)), dst_of(c, 8'(a))});
                    s_exp += 6 + k;
                    n_exp += k;
                end
        pulse_start(s_cyc);
        if (restart_after > 0) begin
            repeat (restart_after) @(negedge clk);
            chk({tag, "_busy_mid"}, out_busy, 1);
            pulse_start(dummy);
        end
        for (int i = 0; i < 2000 && n_done == 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk({tag, "_timeout"}, (n_done == 0), 0);
        chk({tag, "_valid_cnt"}, n_valid, n_exp);
        chk({tag, "_enable_cycles"}, n_en, s_exp);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_done_latency"}, done_cyc - s_cyc, s_exp + 3);
        chk({tag, "_sb_drained"}, exp_q.size(), 0);
        chk({tag, "_idle_after"}, {out_busy, bus.out_motion_update_enable, bus.out_rden}, 0);
`ifdef DISPATCH_STATS_EN
        chk({tag, "_total_particles"}, out_total_particles, n_exp);
        chk({tag, "_empty_cells"}, out_empty_cells, e_exp);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_data"}, {bus.out_data, bus.out_data_dst_cell}, 0);
        chk({tag, "_ctrl"}, {bus.out_rden, bus.out_read_address, bus.out_read_cell,
                              bus.out_motion_update_enable, bus.out_data_valid, out_busy, out_done}, 0);
    endtask

    initial begin
        int s, found;
        foreach (cnt[i]) cnt[i] = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("after_reset");

        cnt = '{3, 0, 2, 1, 0, 0, 4, 0};
        run_pass("mixed", 0);

        cnt = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_pass("empty", 0);

        cnt = '{5, 0, 0, 0, 0, 0, 0, 0};
        fixed_dst = 1'b1;
        run_pass("dst142", 0);
        chk("dst142_cache_count", n_142, 5);
        fixed_dst = 1'b0;

        cnt = '{3, 0, 2, 1, 0, 0, 4, 0};
        run_pass("restart", 6);

        cnt = '{5, 0, 0, 0, 0, 0, 0, 0};
        pulse_start(s);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (bus.out_rden && bus.out_read_address != 8'h0) found = 1;
        end
        chk("reach_rd_part", found, 1);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        cnt = '{2, 0, 4, 0, 0, 0, 0, 0};
        run_pass("post_reset", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
